// File: rtl/tff_ctrl_pkg.sv
// Shared definitions for the toggle flip-flop control stage: FSM encoding and divider limits.
package tff_ctrl_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  // Divider values at or below this collapse to "strobe every cycle".
  localparam int unsigned DIV_MIN = 1;

endpackage

// File: rtl/req_sync_edge.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge detector.
module req_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // s1/s2 resolve metastability; s3 is the one-cycle delay for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/en_toggle_gen.sv
// Programmable-rate enable strobe generator with a synchronised toggle request that is
// held pending and released on the next strobe.
module en_toggle_gen
  import tff_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             clear,
  input  logic [CNT_W-1:0] div,
  input  logic             tog_req,
  output logic             en_out,
  output logic             toggle_out,
  output logic             tog_pending,
  output logic             tog_lost
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] limit;
  logic             pending;
  logic             rise;
  logic             active;
  logic             strobe;

  req_sync_edge u_req_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (tog_req),
    .rise     (rise)
  );

  // Comparing with >= lets a live drop in div force an immediate strobe instead of wrapping.
  assign limit  = (div <= CNT_W'(DIV_MIN)) ? '0 : (div - CNT_W'(1));
  assign active = (state == RUNNING) && run;
  assign strobe = active && (cnt >= limit);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= STOPPED;
      cnt        <= '0;
      pending    <= 1'b0;
      en_out     <= 1'b0;
      toggle_out <= 1'b0;
      tog_lost   <= 1'b0;
    end else if (clear) begin
      cnt        <= '0;
      pending    <= 1'b0;
      en_out     <= 1'b0;
      toggle_out <= 1'b0;
      tog_lost   <= 1'b0;
    end else begin
      case (state)
        STOPPED: if (run)  state <= RUNNING;
        RUNNING: if (!run) state <= STOPPED;
        default:           state <= STOPPED;
      endcase

      if (strobe) begin
        cnt <= '0;
      end else if (active) begin
        cnt <= cnt + CNT_W'(1);
      end

      // A rise landing on a strobe edge is not released now; it becomes the next pending request.
      en_out     <= strobe;
      toggle_out <= strobe & pending;
      pending    <= rise | (pending & ~strobe);
      tog_lost   <= rise & pending & ~strobe;
    end
  end

  assign tog_pending = pending;

endmodule

// File: doc/en_toggle_gen.md
# en_toggle_gen

Control stage that feeds the registered-toggle flip-flop bank: it generates the single-cycle `en` strobe at a programmable rate and the matching `toggle` qualifier. `toggle` comes from an asynchronous user request, such as a pushbutton or keyboard event. Requests are synchronised, edge-detected, held pending, and released together with the next strobe, so the downstream flop inverts exactly once per request on a strobe boundary.

## Interface
Parameters:
- `CNT_W`, 32: width of divider counter and `div` input.

Ports (clock and reset first):
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset; synchronous, active-low.
- `run`  in  1  level; 1 = divider counts and strobes, 0 = paused.
- `clear`  in  1  synchronous; zeroes counter and drops any pending request.
- `div`  in  CNT_W  strobe period in `clk` cycles; 0 and 1 both mean every cycle.
- `tog_req`  in  1  asynchronous toggle request; rising edge = one request.
- `en_out`  out  1  one-cycle strobe; drives downstream `en`.
- `toggle_out`  out  1  high only in the cycle `en_out` is high, when a request is released.
- `tog_pending`  out  1  a request is waiting for the next strobe.
- `tog_lost`  out  1  one-cycle pulse: a request was merged into an already pending one.

## Operation
- Reset (`rst_n`=0 at a clock edge): `cnt`=0, sync flops=0, pending=0, state STOPPED. All outputs are 0 the cycle after.
- FSM states: STOPPED, RUNNING.
  - STOPPED→RUNNING: at the edge where `run`=1.
  - RUNNING→STOPPED: at the edge where `run`=0.
- STOPPED behaviour: `cnt` holds its value, `en_out`=0, `toggle_out`=0. Request capture continues while stopped.
- Divider, in RUNNING:
  - The strobe condition is `cnt >= div-1`, with `div` 0 or 1 treated as a limit of 0.
  - On a strobe: `cnt`←0 and `en_out`←1. Otherwise `cnt`←`cnt`+1 and `en_out`←0.
  - `div` is sampled live. Lowering `div` below the current `cnt` forces a strobe at the next edge, so there is no wrap-around through 2^CNT_W.
- Request path:
  - `tog_req` passes through two flops (`s1`, `s2`) and then a delay flop `s3`.
  - A request is seen when `rise = s2 & ~s3`.
- Pending register: `pending_next = rise | (pending & ~strobe)`.
  - At a strobe edge, `toggle_out`←`pending` (the old value).
  - A `rise` coinciding with a strobe is therefore not released now. It becomes the new pending request.
- `tog_lost` ← `rise & pending & ~strobe`. Multiple requests between strobes collapse to one toggle.
- `clear` (priority below reset, above everything else):
  - `cnt`←0, `pending`←0, `en_out`←0, `toggle_out`←0.
  - FSM state is unchanged. Sync flops keep running.
- `tog_pending` = the `pending` register, directly.

## Timing
- Request latency: if `tog_req` is first high at edge E1, then `s1` is set at E1, `s2` at E2, and `pending` at E3. `tog_pending` is visible after E3.
- Release: `toggle_out` and `en_out` are asserted by the same edge and are high for exactly one cycle. `toggle_out` is never high without `en_out`.
- Strobe spacing: with constant `div`=N≥2 and `run` held high, strobes occur every N cycles.
  - The first strobe after reset+run comes N edges after the first RUNNING edge.
  - With `div`≤1, `en_out` is high every cycle from the second RUNNING edge onward.
- Pause: deasserting `run` drops `en_out` at the next edge. Resuming continues from the held `cnt`.
- Reset mid-operation: takes effect at the next edge and overrides `run`, `clear`, and any pending request.

## Structure
- Package `tff_ctrl_pkg`: holds the FSM enum (`STOPPED`, `RUNNING`) and `DIV_MIN` = 1.
- Sub-module `req_sync_edge`: 2-flop synchroniser plus edge detector (`clk`, `rst_n`, `async_in`, `rise`). It is reused by other button inputs in the design.
- Top holds the FSM, divider counter, pending/release logic, and output registers. All outputs are registered.

## Test plan
- Reset → all outputs 0. Release `rst_n` with `run`=1, `div`=4 → `en_out` pulses at RUNNING edges 4, 8, 12, with `toggle_out`=0 throughout.
- `div`=5, running, single `tog_req` pulse → `tog_pending`=1 three edges later. The next `en_out` has `toggle_out`=1, and `tog_pending`=0 after it.
- Three `tog_req` pulses, each 4 cycles apart, with `div`=100 → `tog_lost` pulses twice. Exactly one strobe carries `toggle_out`=1.
- `rise` arranged to coincide with a strobe edge while a request is pending → that strobe has `toggle_out`=1, `tog_pending` stays 1, and the next strobe also has `toggle_out`=1.
- `div`=20, `cnt`=15, change `div` to 3 → strobe at the next edge, then a strobe every 3 cycles.
- `run`=0 for 10 cycles at `cnt`=2 (`div`=6) → no strobes, then resume and strobe after 4 edges. Separately, `clear` with a request pending → `tog_pending`=0, `cnt`=0, and the next strobe has `toggle_out`=0.
